// File: rtl/stack_pkg.sv
// ============================================================================
//  Module      : stack_pkg
//  Description : Shared types and constants for the WebAssembly operand stack:
//                op encodings, sticky trap codes and value type tags.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package stack_pkg;

    typedef enum logic [2:0] {
        OP_NOP    = 3'd0,
        OP_PUSH   = 3'd1,
        OP_POP1   = 3'd2,
        OP_POP2   = 3'd3,
        OP_UNARY  = 3'd4,
        OP_BINARY = 3'd5,
        OP_SELECT = 3'd6,
        OP_DROPN  = 3'd7
    } stack_op_t;

    localparam logic [3:0] TRAP_NONE      = 4'd0;
    localparam logic [3:0] TRAP_OVERFLOW  = 4'd1;
    localparam logic [3:0] TRAP_UNDERFLOW = 4'd2;
    localparam logic [3:0] TRAP_BADOP     = 4'd3;

    localparam logic [1:0] TYPE_I32 = 2'd0;
    localparam logic [1:0] TYPE_I64 = 2'd1;
    localparam logic [1:0] TYPE_F32 = 2'd2;
    localparam logic [1:0] TYPE_F64 = 2'd3;

    // Entries consumed by ops with a fixed operand count; DROPN takes op_n instead.
    function automatic logic [1:0] op_fixed_pops(input stack_op_t op);
        case (op)
            OP_POP1, OP_UNARY:   return 2'd1;
            OP_POP2, OP_BINARY:  return 2'd2;
            OP_SELECT:           return 2'd3;
            default:             return 2'd0;
        endcase
    endfunction

    // True for ops that leave a freshly written value on top.
    function automatic logic op_pushes(input stack_op_t op);
        case (op)
            OP_PUSH, OP_UNARY, OP_BINARY, OP_SELECT: return 1'b1;
            default:                                 return 1'b0;
        endcase
    endfunction

endpackage

`default_nettype wire

// File: rtl/stack_regfile.sv
// ============================================================================
//  Module      : stack_regfile
//  Description : Operand stack storage, one write port and two asynchronous
//                read ports; contents are deliberately not reset.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module stack_regfile #(
    parameter int DW       = 64,
    parameter int DEPTH_LG = 4,
    parameter int TW       = 2
) (
    input  logic                 clk,
    input  logic                 we,
    input  logic [DEPTH_LG-1:0]  waddr,
    input  logic [DW+TW-1:0]     wdata,
    input  logic [DEPTH_LG-1:0]  raddr0,
    input  logic [DEPTH_LG-1:0]  raddr1,
    output logic [DW+TW-1:0]     rdata0,
    output logic [DW+TW-1:0]     rdata1
);

    localparam int DEPTH = 2 ** DEPTH_LG;

    logic [DW+TW-1:0] r_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            r_mem[waddr] <= wdata;
        end
    end

    assign rdata0 = r_mem[raddr0];
    assign rdata1 = r_mem[raddr1];

endmodule

`default_nettype wire

// File: rtl/operand_stack.sv
// ============================================================================
//  Module      : operand_stack
//  Description : Typed WebAssembly operand stack executing one push/pop/
//                rewrite/drop-N op per clock, with sticky trap reporting.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module operand_stack
    import stack_pkg::*;
#(
    parameter int DW       = 64,
    parameter int DEPTH_LG = 4,
    parameter int TW       = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 op_valid,
    input  stack_op_t            op,
    input  logic [DEPTH_LG:0]    op_n,
    input  logic [DW-1:0]        in_data,
    input  logic [TW-1:0]        in_type,
    output logic [DW-1:0]        top0_data,
    output logic [TW-1:0]        top0_type,
    output logic [DW-1:0]        top1_data,
    output logic [TW-1:0]        top1_type,
    output logic [DEPTH_LG:0]    count,
    output logic [DW-1:0]        result,
    output logic                 result_empty,
    output logic [3:0]           trap
);

    localparam int              CW      = DEPTH_LG + 1;
    localparam logic [CW-1:0]   c_depth = CW'(2 ** DEPTH_LG);

    logic [CW-1:0]        r_count;
    logic [3:0]           r_trap;

    logic [CW-1:0]        w_need;
    logic                 w_push;
    logic                 w_bad;
    logic                 w_overflow;
    logic                 w_underflow;
    logic [3:0]           w_fault;
    logic                 w_accept;
    logic                 w_commit;
    logic [CW-1:0]        w_next;
    logic                 w_we;
    logic [DEPTH_LG-1:0]  w_waddr;
    logic [DEPTH_LG-1:0]  w_raddr0;
    logic [DEPTH_LG-1:0]  w_raddr1;
    logic [DW+TW-1:0]     w_rdata0;
    logic [DW+TW-1:0]     w_rdata1;

    // ------------------------------------------------------------------
    // Op decode and bounds check
    // ------------------------------------------------------------------
    always_comb begin
        w_need = (op == OP_DROPN) ? op_n : CW'(op_fixed_pops(op));
        w_push = op_pushes(op);
        w_bad  = 1'b0;
        case (op)
            OP_NOP, OP_PUSH, OP_POP1, OP_POP2,
            OP_UNARY, OP_BINARY, OP_SELECT, OP_DROPN: w_bad = 1'b0;
            default:                                  w_bad = 1'b1;
        endcase
    end

    // Only a pure push grows the stack, so it is the only overflow source.
    assign w_overflow  = (op == OP_PUSH) && (r_count == c_depth);
    assign w_underflow = (w_need > r_count);

    always_comb begin
        w_fault = TRAP_NONE;
        if (w_bad) begin
            w_fault = TRAP_BADOP;
        end else if (w_underflow) begin
            w_fault = TRAP_UNDERFLOW;
        end else if (w_overflow) begin
            w_fault = TRAP_OVERFLOW;
        end
    end

    assign w_accept = op_valid && (r_trap == TRAP_NONE);
    assign w_commit = w_accept && (w_fault == TRAP_NONE);
    assign w_next   = r_count - w_need + (w_push ? CW'(1) : CW'(0));

    // ------------------------------------------------------------------
    // Count and sticky trap registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_count <= '0;
            r_trap  <= TRAP_NONE;
        end else if (w_accept) begin
            if (w_fault != TRAP_NONE) begin
                r_trap <= w_fault;
            end else begin
                r_count <= w_next;
            end
        end
    end

    // ------------------------------------------------------------------
    // Storage: the new top slot is always next_count-1
    // ------------------------------------------------------------------
    assign w_we     = w_commit && w_push;
    assign w_waddr  = DEPTH_LG'(w_next - CW'(1));
    assign w_raddr0 = DEPTH_LG'(r_count - CW'(1));
    assign w_raddr1 = DEPTH_LG'(r_count - CW'(2));

    stack_regfile #(
        .DW       (DW),
        .DEPTH_LG (DEPTH_LG),
        .TW       (TW)
    ) u_regfile (
        .clk    (clk),
        .we     (w_we),
        .waddr  (w_waddr),
        .wdata  ({in_type, in_data}),
        .raddr0 (w_raddr0),
        .raddr1 (w_raddr1),
        .rdata0 (w_rdata0),
        .rdata1 (w_rdata1)
    );

    // Unoccupied slots read as zero so stale storage never leaks out.
    assign top0_data    = (r_count != '0)       ? w_rdata0[DW-1:0]   : '0;
    assign top0_type    = (r_count != '0)       ? w_rdata0[DW +: TW] : '0;
    assign top1_data    = (r_count >= CW'(2))   ? w_rdata1[DW-1:0]   : '0;
    assign top1_type    = (r_count >= CW'(2))   ? w_rdata1[DW +: TW] : '0;
    assign count        = r_count;
    assign result       = top0_data;
    assign result_empty = (r_count == '0);
    assign trap         = r_trap;

endmodule

`default_nettype wire

// File: tb/tb_operand_stack.sv
// ============================================================================
//  Module      : tb_operand_stack
//  Description : Directed bench for operand_stack with a queue-based reference
//                stack and an expected-output scoreboard.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_operand_stack;
    import stack_pkg::*;

    localparam int DW       = 64;
    localparam int DEPTH_LG = 2;
    localparam int TW       = 2;
    localparam int DEPTH    = 4;

    logic                clk = 1'b0;
    logic                reset;
    logic                op_valid;
    stack_op_t           op;
    logic [DEPTH_LG:0]   op_n;
    logic [DW-1:0]       in_data;
    logic [TW-1:0]       in_type;
    logic [DW-1:0]       top0_data;
    logic [TW-1:0]       top0_type;
    logic [DW-1:0]       top1_data;
    logic [TW-1:0]       top1_type;
    logic [DEPTH_LG:0]   count;
    logic [DW-1:0]       result;
    logic                result_empty;
    logic [3:0]          trap;

    always #5 clk = ~clk;

    operand_stack #(
        .DW       (DW),
        .DEPTH_LG (DEPTH_LG),
        .TW       (TW)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .op_valid     (op_valid),
        .op           (op),
        .op_n         (op_n),
        .in_data      (in_data),
        .in_type      (in_type),
        .top0_data    (top0_data),
        .top0_type    (top0_type),
        .top1_data    (top1_data),
        .top1_type    (top1_type),
        .count        (count),
        .result       (result),
        .result_empty (result_empty),
        .trap         (trap)
    );

    typedef struct {
        int          cnt;
        logic [63:0] t0;
        logic [1:0]  ty0;
        logic [63:0] t1;
        logic [1:0]  ty1;
        logic [3:0]  trp;
        logic        empty;
    } exp_t;

    int             errors = 0;
    int             checks = 0;
    logic [65:0]    m_stk [$];
    logic [3:0]     m_trap = 4'd0;
    exp_t           exp_q [$];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Reference: a plain queue used as a stack, pop-then-push semantics.
    task automatic model_apply(input logic v, input stack_op_t o, input int n,
                               input logic [63:0] d, input logic [1:0] t);
        int need;
        int npush;
        int sz;
        if (!v || m_trap != 4'd0) return;
        sz = m_stk.size();
        case (o)
            OP_NOP:    begin need = 0; npush = 0; end
            OP_PUSH:   begin need = 0; npush = 1; end
            OP_POP1:   begin need = 1; npush = 0; end
            OP_POP2:   begin need = 2; npush = 0; end
            OP_UNARY:  begin need = 1; npush = 1; end
            OP_BINARY: begin need = 2; npush = 1; end
            OP_SELECT: begin need = 3; npush = 1; end
            default:   begin need = n; npush = 0; end
        endcase
        if (need > sz) begin
            m_trap = 4'd2;
        end else if (sz - need + npush > DEPTH) begin
            m_trap = 4'd1;
        end else begin
            repeat (need) void'(m_stk.pop_back());
            if (npush != 0) m_stk.push_back({t, d});
        end
    endtask

    function automatic exp_t model_outputs();
        exp_t e;
        int   sz;
        sz      = m_stk.size();
        e.cnt   = sz;
        e.t0    = (sz >= 1) ? m_stk[sz-1][63:0]  : 64'd0;
        e.ty0   = (sz >= 1) ? m_stk[sz-1][65:64] : 2'd0;
        e.t1    = (sz >= 2) ? m_stk[sz-2][63:0]  : 64'd0;
        e.ty1   = (sz >= 2) ? m_stk[sz-2][65:64] : 2'd0;
        e.trp   = m_trap;
        e.empty = (sz == 0);
        return e;
    endfunction

    task automatic compare_outputs(input string tag);
        exp_t e;
        if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $error("FAIL %s observed=no_expected_entry expected=entry", tag);
            return;
        end
        e = exp_q.pop_front();
        check({tag, ".count"}, 64'(count),        64'(e.cnt));
        check({tag, ".top0"},  top0_data,         e.t0);
        check({tag, ".ty0"},   64'(top0_type),    64'(e.ty0));
        check({tag, ".top1"},  top1_data,         e.t1);
        check({tag, ".ty1"},   64'(top1_type),    64'(e.ty1));
        check({tag, ".result"}, result,           e.t0);
        check({tag, ".empty"}, 64'(result_empty), 64'(e.empty));
        check({tag, ".trap"},  64'(trap),         64'(e.trp));
    endtask

    task automatic check_now(input string tag);
        exp_q.push_back(model_outputs());
        compare_outputs(tag);
    endtask

    task automatic step(input string tag, input logic v, input stack_op_t o, input int n,
                        input logic [63:0] d, input logic [1:0] t);
        op_valid = v;
        op       = o;
        op_n     = (DEPTH_LG+1)'(n);
        in_data  = d;
        in_type  = t;
        model_apply(v, o, n, d, t);
        exp_q.push_back(model_outputs());
        @(posedge clk);
        #1;
        compare_outputs(tag);
    endtask

    task automatic apply_reset();
        op_valid = 1'b0;
        reset    = 1'b0;
        m_stk.delete();
        m_trap   = 4'd0;
        @(posedge clk);
        @(posedge clk);
        #3 reset = 1'b1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset    = 1'b0;
        op_valid = 1'b0;
        op       = OP_NOP;
        op_n     = '0;
        in_data  = '0;
        in_type  = '0;

        apply_reset();
        check_now("reset");

        // Three pushes, binary rewrite, then drop everything.
        step("push5", 1'b1, OP_PUSH, 0, 64'd5, TYPE_I32);
        step("push7", 1'b1, OP_PUSH, 0, 64'd7, TYPE_I32);
        step("push9", 1'b1, OP_PUSH, 0, 64'd9, TYPE_I32);
        check("t1.count", 64'(count), 64'd3);
        check("t1.top0",  top0_data,  64'd9);
        check("t1.top1",  top1_data,  64'd7);
        check("t1.empty", 64'(result_empty), 64'd0);
        step("binary", 1'b1, OP_BINARY, 0, 64'd16, TYPE_I64);
        check("t2.top0",  top0_data,  64'd16);
        check("t2.top1",  top1_data,  64'd5);
        check("t2.count", 64'(count), 64'd2);
        step("drop2", 1'b1, OP_DROPN, 2, 64'd0, TYPE_I32);
        check("t2.empty", 64'(result_empty), 64'd1);

        // Fill to depth, overflow, then sticky trap ignores a POP1.
        step("fill1", 1'b1, OP_PUSH, 0, 64'h1, TYPE_I64);
        step("fill2", 1'b1, OP_PUSH, 0, 64'h2, TYPE_F32);
        step("fill3", 1'b1, OP_PUSH, 0, 64'h3, TYPE_F64);
        step("fill4", 1'b1, OP_PUSH, 0, 64'h4, TYPE_I32);
        step("ovf",   1'b1, OP_PUSH, 0, 64'hAA, TYPE_I32);
        check("ovf.trap",  64'(trap),  64'd1);
        check("ovf.count", 64'(count), 64'd4);
        check("ovf.top0",  top0_data,  64'h4);
        step("sticky_pop", 1'b1, OP_POP1, 0, 64'd0, TYPE_I32);
        check("sticky.count", 64'(count), 64'd4);

        // Underflow on empty, and SELECT with only two entries.
        apply_reset();
        check_now("reset2");
        step("pop_empty", 1'b1, OP_POP1, 0, 64'd0, TYPE_I32);
        check("unf.trap", 64'(trap), 64'd2);
        apply_reset();
        step("s_push1", 1'b1, OP_PUSH, 0, 64'h11, TYPE_F32);
        step("s_push2", 1'b1, OP_PUSH, 0, 64'h22, TYPE_F64);
        step("select",  1'b1, OP_SELECT, 0, 64'h33, TYPE_I32);
        check("sel.trap",  64'(trap),  64'd2);
        check("sel.count", 64'(count), 64'd2);

        // op_valid low holds state; DROPN 0 is a no-op; boundary drops.
        apply_reset();
        step("h_push", 1'b1, OP_PUSH, 0, 64'h1, TYPE_I32);
        for (int i = 0; i < 5; i++) begin
            step("idle", 1'b0, OP_PUSH, int'($urandom_range(0, 7)), {$urandom, $urandom}, 2'($urandom));
        end
        check("idle.count", 64'(count), 64'd1);
        step("drop0",  1'b1, OP_DROPN, 0, 64'd0, TYPE_I32);
        step("h_p2",   1'b1, OP_PUSH, 0, 64'h2, TYPE_I64);
        step("h_p3",   1'b1, OP_PUSH, 0, 64'h3, TYPE_I64);
        step("unary",  1'b1, OP_UNARY, 0, 64'h77, TYPE_F32);
        step("pop2",   1'b1, OP_POP2, 0, 64'd0, TYPE_I32);
        step("h_p4",   1'b1, OP_PUSH, 0, 64'h4, TYPE_I32);
        step("h_p5",   1'b1, OP_PUSH, 0, 64'h5, TYPE_I32);
        step("h_p6",   1'b1, OP_PUSH, 0, 64'h6, TYPE_I32);
        step("drop4",  1'b1, OP_DROPN, 4, 64'd0, TYPE_I32);
        step("h_p7",   1'b1, OP_PUSH, 0, 64'h7, TYPE_I32);
        step("drop5",  1'b1, OP_DROPN, 5, 64'd0, TYPE_I32);
        check("drop5.trap", 64'(trap), 64'd2);

        // Async reset in the middle of a push burst.
        apply_reset();
        step("b_p0", 1'b1, OP_PUSH, 0, 64'hA0, TYPE_I32);
        step("b_p1", 1'b1, OP_PUSH, 0, 64'hA1, TYPE_I32);
        step("b_p2", 1'b1, OP_PUSH, 0, 64'hA2, TYPE_I32);
        #2 reset = 1'b0;
        #1;
        check("arst.count", 64'(count), 64'd0);
        check("arst.trap",  64'(trap),  64'd0);
        check("arst.empty", 64'(result_empty), 64'd1);
        check("arst.top0",  top0_data,  64'd0);
        @(posedge clk);
        #1;
        check("arst.hold", 64'(count), 64'd0);
        #1 reset = 1'b1;
        m_stk.delete();
        m_trap = 4'd0;
        step("r_p0", 1'b1, OP_PUSH, 0, 64'hB0, TYPE_F64);
        step("r_p1", 1'b1, OP_PUSH, 0, 64'hB1, TYPE_F32);
        check("resume.top1", top1_data, 64'hB0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
